// File: rtl/free_list_pkg.sv
// Shared definitions for the rename-stage physical-register free list.
//
// Holds the sizing constants (physical/architectural register counts,
// ROB depth, zero register), the derived index and pointer widths, and the
// structs that carry register tags between the free list and the ROB.
// The free-list state struct groups the circular array with its pointers.
package free_list_pkg;

   localparam int NUM_PR   = 64;
   localparam int NUM_AR   = 32;
   localparam int NUM_ROB  = 32;
   localparam int ZERO_REG = 31;
   localparam int FL_SIZE  = NUM_PR - NUM_AR;

   localparam int AR_W  = 5;
   localparam int PR_W  = $clog2(NUM_PR);
   localparam int ROB_W = $clog2(NUM_ROB);
   // One extra bit beyond the array index: the wrap bit that tells a full
   // list (tail - head == FL_SIZE) from an empty one (tail == head).
   localparam int PTR_W = $clog2(FL_SIZE) + 1;

   typedef logic [PR_W-1:0]  pr_idx_t;
   typedef logic [AR_W-1:0]  ar_idx_t;
   typedef logic [PTR_W-1:0] ptr_t;

   // The architectural zero register maps to the physical register of the
   // same number and is never renamed.
   localparam pr_idx_t ZERO_PR  = pr_idx_t'(ZERO_REG);
   localparam ar_idx_t ZERO_ARCH = ar_idx_t'(ZERO_REG);

   typedef struct packed {
      pr_idx_t T_idx;
   } FL_ROB_OUT_t;

   typedef struct packed {
      pr_idx_t Told_idx;
   } ROB_FL_OUT_t;

   typedef struct packed {
      pr_idx_t [FL_SIZE-1:0] fl;
      ptr_t                  head;
      ptr_t                  tail;
   } FL_t;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return p + ptr_t'(1);
   endfunction

endpackage

// File: rtl/free_list.sv
// Physical-register free list for an R10000-style rename stage.
//
// Supplies the next free physical register (T_idx) to the ROB and map table
// at dispatch, reclaims Told_idx when the ROB retires an instruction, and on
// a branch mispredict restores its head pointer from a per-ROB-entry
// checkpoint so registers taken by squashed instructions become free again.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   en                  global enable; no state changes when low
//   dispatch_en         dispatch request this cycle
//   dispatch_dest_idx   architectural destination of the dispatching instr
//   dispatch_ROB_idx    ROB slot being written by that dispatch
//   retire_en           ROB head retiring this cycle
//   retire_dest_idx     architectural destination of the retiring instr
//   ROB_FL_out          Told_idx of the retiring instruction
//   rollback_en         branch mispredict rollback
//   ROB_rollback_idx    ROB index of the mispredicted branch
//   FL_valid            a register is available for the current dispatch
//   FL_ROB_out          T_idx for the dispatching instruction (same cycle)
//   free_count          number of free entries (tail - head)
module free_list
   import free_list_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic              dispatch_en,
   input  logic [AR_W-1:0]   dispatch_dest_idx,
   input  logic [ROB_W-1:0]  dispatch_ROB_idx,
   input  logic              retire_en,
   input  logic [AR_W-1:0]   retire_dest_idx,
   input  ROB_FL_OUT_t       ROB_FL_out,
   input  logic              rollback_en,
   input  logic [ROB_W-1:0]  ROB_rollback_idx,
   output logic              FL_valid,
   output FL_ROB_OUT_t       FL_ROB_out,
   output logic [PTR_W-1:0]  free_count
);

   FL_t  fl_reg;
   ptr_t ckpt_reg [NUM_ROB];

   ptr_t head_next;
   ptr_t tail_next;
   logic zero_dest;
   logic ckpt_wr;
   logic pop;
   logic push;
   logic rollback;

   always_comb begin
      zero_dest  = (dispatch_dest_idx == ZERO_ARCH);
      free_count = fl_reg.tail - fl_reg.head;
      FL_valid   = (free_count != '0) || zero_dest;

      FL_ROB_out.T_idx = zero_dest ? ZERO_PR
                                   : fl_reg.fl[fl_reg.head[PTR_W-2:0]];

      rollback = en && rollback_en;
      // A dispatch is accepted when the ROB also takes it (no rollback) and
      // the list can serve it; a stalled dispatch leaves the checkpoint alone.
      ckpt_wr  = en && dispatch_en && !rollback_en && FL_valid;
      pop      = ckpt_wr && !zero_dest;
      push     = en && retire_en && (retire_dest_idx != ZERO_ARCH);

      head_next = fl_reg.head;
      if (rollback) begin
         head_next = ckpt_reg[ROB_rollback_idx];
      end else if (pop) begin
         head_next = ptr_inc(fl_reg.head);
      end

      tail_next = push ? ptr_inc(fl_reg.tail) : fl_reg.tail;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < FL_SIZE; i++) begin
            fl_reg.fl[i] <= pr_idx_t'(NUM_AR + i);
         end
         fl_reg.head <= '0;
         fl_reg.tail <= ptr_t'(FL_SIZE);
         for (int i = 0; i < NUM_ROB; i++) begin
            ckpt_reg[i] <= '0;
         end
      end else begin
         fl_reg.head <= head_next;
         fl_reg.tail <= tail_next;
         // The pushed slot lies outside the live range, so a same-cycle pop
         // never needs the value being written.
         if (push) begin
            fl_reg.fl[fl_reg.tail[PTR_W-2:0]] <= ROB_FL_out.Told_idx;
         end
         // Rollback is excluded from ckpt_wr, so head_next here is the
         // post-dispatch head.
         if (ckpt_wr) begin
            ckpt_reg[dispatch_ROB_idx] <= head_next;
         end
      end
   end

   // Occupancy can never exceed the list size; a push into a full list with
   // nothing leaving would lose a register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (free_count <= ptr_t'(FL_SIZE));
         assert (!(push && !pop && !rollback && free_count == ptr_t'(FL_SIZE)));
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list. Each task drives one scenario
// and compares outputs against hand-computed values; inputs change 1 ns after
// the rising edge and combinational outputs are sampled 1 ns later.
module tb_free_list;
   import free_list_pkg::*;

   logic              clock;
   logic              reset;
   logic              en;
   logic              dispatch_en;
   logic [AR_W-1:0]   dispatch_dest_idx;
   logic [ROB_W-1:0]  dispatch_ROB_idx;
   logic              retire_en;
   logic [AR_W-1:0]   retire_dest_idx;
   ROB_FL_OUT_t       rob_fl_out;
   logic              rollback_en;
   logic [ROB_W-1:0]  ROB_rollback_idx;
   logic              fl_valid;
   FL_ROB_OUT_t       fl_rob_out;
   logic [PTR_W-1:0]  free_count;

   int errors = 0;
   int checks = 0;

   free_list dut (
      .clock             (clock),
      .reset             (reset),
      .en                (en),
      .dispatch_en       (dispatch_en),
      .dispatch_dest_idx (dispatch_dest_idx),
      .dispatch_ROB_idx  (dispatch_ROB_idx),
      .retire_en         (retire_en),
      .retire_dest_idx   (retire_dest_idx),
      .ROB_FL_out        (rob_fl_out),
      .rollback_en       (rollback_en),
      .ROB_rollback_idx  (ROB_rollback_idx),
      .FL_valid          (fl_valid),
      .FL_ROB_out        (fl_rob_out),
      .free_count        (free_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      en = 1'b1; dispatch_en = 1'b0; retire_en = 1'b0; rollback_en = 1'b0;
      dispatch_dest_idx = 5'd1; dispatch_ROB_idx = '0;
      retire_dest_idx = 5'd1; rob_fl_out.Told_idx = '0; ROB_rollback_idx = '0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
   endtask

   task automatic test_reset();
      pulse_reset();
      #1;
      $display("reset: free_count=%0d FL_valid=%0b T_idx=%0d", free_count, fl_valid, fl_rob_out.T_idx);
      checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", free_count); end
      checks++; if (fl_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %0b expected 1", fl_valid); end
      checks++; if (fl_rob_out.T_idx !== 6'd32) begin errors++; $display("FAIL reset_T_idx: got %0d expected 32", fl_rob_out.T_idx); end
   endtask

   task automatic test_dispatch();
      for (int i = 0; i < 3; i++) begin
         dispatch_en = 1'b1; dispatch_dest_idx = 5'(i + 1); dispatch_ROB_idx = 5'(i);
         #1;
         checks++; if (fl_rob_out.T_idx !== 6'(32 + i)) begin errors++; $display("FAIL dispatch_T_idx[%0d]: got %0d expected %0d", i, fl_rob_out.T_idx, 32 + i); end
         checks++; if (fl_valid !== 1'b1) begin errors++; $display("FAIL dispatch_valid[%0d]: got %0b expected 1", i, fl_valid); end
         step();
         $display("dispatch dest=%0d rob=%0d -> free_count=%0d", i + 1, i, free_count);
         checks++; if (free_count !== 6'(31 - i)) begin errors++; $display("FAIL dispatch_count[%0d]: got %0d expected %0d", i, free_count, 31 - i); end
      end
      // With en low nothing may change.
      en = 1'b0; dispatch_dest_idx = 5'd4; dispatch_ROB_idx = 5'd20;
      step();
      idle(); dispatch_dest_idx = 5'd4;
      #1;
      $display("disabled dispatch -> free_count=%0d T_idx=%0d", free_count, fl_rob_out.T_idx);
      checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL en_low_count: got %0d expected 29", free_count); end
      checks++; if (fl_rob_out.T_idx !== 6'd35) begin errors++; $display("FAIL en_low_T_idx: got %0d expected 35", fl_rob_out.T_idx); end
   endtask

   task automatic test_zero_dest();
      dispatch_en = 1'b1; dispatch_dest_idx = 5'd31; dispatch_ROB_idx = 5'd3;
      #1;
      checks++; if (fl_rob_out.T_idx !== 6'd31) begin errors++; $display("FAIL zero_T_idx: got %0d expected 31", fl_rob_out.T_idx); end
      checks++; if (fl_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %0b expected 1", fl_valid); end
      step();
      dispatch_en = 1'b0; dispatch_dest_idx = 5'd5;
      #1;
      $display("zero-dest dispatch rob=3 -> free_count=%0d next T_idx=%0d", free_count, fl_rob_out.T_idx);
      checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL zero_count: got %0d expected 29", free_count); end
      checks++; if (fl_rob_out.T_idx !== 6'd35) begin errors++; $display("FAIL zero_head: got %0d expected 35", fl_rob_out.T_idx); end
      // Pop one more, then roll back to the zero-dest checkpoint (head 3).
      dispatch_en = 1'b1; dispatch_ROB_idx = 5'd4;
      step();
      idle(); rollback_en = 1'b1; ROB_rollback_idx = 5'd3;
      step();
      idle(); dispatch_dest_idx = 5'd5;
      #1;
      $display("rollback to rob=3 -> free_count=%0d T_idx=%0d", free_count, fl_rob_out.T_idx);
      checks++; if (fl_rob_out.T_idx !== 6'd35) begin errors++; $display("FAIL zero_ckpt_T_idx: got %0d expected 35", fl_rob_out.T_idx); end
      checks++; if (free_count !== 6'd29) begin errors++; $display("FAIL zero_ckpt_count: got %0d expected 29", free_count); end
   endtask

   task automatic test_full();
      pulse_reset();
      for (int i = 0; i < 32; i++) begin
         dispatch_en = 1'b1; dispatch_dest_idx = 5'd1; dispatch_ROB_idx = 5'(i);
         #1;
         checks++; if (fl_rob_out.T_idx !== 6'(32 + i)) begin errors++; $display("FAIL fill_T_idx[%0d]: got %0d expected %0d", i, fl_rob_out.T_idx, 32 + i); end
         step();
      end
      dispatch_ROB_idx = 5'd7;
      #1;
      $display("list drained: free_count=%0d FL_valid=%0b", free_count, fl_valid);
      checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", free_count); end
      checks++; if (fl_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %0b expected 0", fl_valid); end
      step();
      checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL empty_no_pop: got %0d expected 0", free_count); end
      dispatch_dest_idx = 5'd31;
      #1;
      checks++; if (fl_valid !== 1'b1) begin errors++; $display("FAIL empty_zero_valid: got %0b expected 1", fl_valid); end
      idle(); retire_en = 1'b1; retire_dest_idx = 5'd3; rob_fl_out.Told_idx = 6'd5;
      step();
      idle();
      #1;
      $display("retire Told=5 -> free_count=%0d T_idx=%0d", free_count, fl_rob_out.T_idx);
      checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", free_count); end
      checks++; if (fl_rob_out.T_idx !== 6'd5) begin errors++; $display("FAIL wrap_T_idx: got %0d expected 5", fl_rob_out.T_idx); end
      // ROB 7 checkpoint must still hold 8 from the fill, not the stalled request.
      rollback_en = 1'b1; ROB_rollback_idx = 5'd7;
      step();
      idle();
      #1;
      $display("rollback to rob=7 -> free_count=%0d T_idx=%0d", free_count, fl_rob_out.T_idx);
      checks++; if (free_count !== 6'd25) begin errors++; $display("FAIL stall_ckpt_count: got %0d expected 25", free_count); end
      checks++; if (fl_rob_out.T_idx !== 6'd40) begin errors++; $display("FAIL stall_ckpt_T_idx: got %0d expected 40", fl_rob_out.T_idx); end
   endtask

   task automatic test_rollback();
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         dispatch_en = 1'b1; dispatch_dest_idx = 5'd1; dispatch_ROB_idx = 5'(4 + i);
         #1;
         checks++; if (fl_rob_out.T_idx !== 6'(32 + i)) begin errors++; $display("FAIL rb_T_idx[%0d]: got %0d expected %0d", i, fl_rob_out.T_idx, 32 + i); end
         step();
      end
      idle(); rollback_en = 1'b1; ROB_rollback_idx = 5'd4;
      step();
      idle();
      #1;
      $display("rollback to rob=4 -> free_count=%0d T_idx=%0d", free_count, fl_rob_out.T_idx);
      checks++; if (fl_rob_out.T_idx !== 6'd33) begin errors++; $display("FAIL rb_head: got %0d expected 33", fl_rob_out.T_idx); end
      checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL rb_count: got %0d expected 31", free_count); end
   endtask

   task automatic test_back_to_back();
      // Retire and dispatch together: pop reads old head, push goes to tail.
      retire_en = 1'b1; retire_dest_idx = 5'd2; rob_fl_out.Told_idx = 6'd7;
      dispatch_en = 1'b1; dispatch_dest_idx = 5'd1; dispatch_ROB_idx = 5'd10;
      #1;
      checks++; if (fl_rob_out.T_idx !== 6'd33) begin errors++; $display("FAIL b2b_T_idx: got %0d expected 33", fl_rob_out.T_idx); end
      step();
      idle();
      #1;
      $display("retire Told=7 + dispatch -> free_count=%0d T_idx=%0d", free_count, fl_rob_out.T_idx);
      checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL b2b_count: got %0d expected 31", free_count); end
      checks++; if (fl_rob_out.T_idx !== 6'd34) begin errors++; $display("FAIL b2b_next: got %0d expected 34", fl_rob_out.T_idx); end
      // Rollback with a dispatch and a retire in the same cycle: dispatch is
      // dropped, retire still pushes, head comes from ROB 6 checkpoint (3).
      rollback_en = 1'b1; ROB_rollback_idx = 5'd6;
      dispatch_en = 1'b1; dispatch_dest_idx = 5'd1; dispatch_ROB_idx = 5'd12;
      retire_en = 1'b1; retire_dest_idx = 5'd2; rob_fl_out.Told_idx = 6'd9;
      step();
      idle();
      #1;
      $display("rollback rob=6 + dispatch + retire Told=9 -> free_count=%0d T_idx=%0d", free_count, fl_rob_out.T_idx);
      checks++; if (fl_rob_out.T_idx !== 6'd35) begin errors++; $display("FAIL rb_disp_T_idx: got %0d expected 35", fl_rob_out.T_idx); end
      checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL rb_disp_count: got %0d expected 31", free_count); end
   endtask

   task automatic test_mid_reset();
      en = 1'b1; dispatch_en = 1'b1; dispatch_dest_idx = 5'd3; dispatch_ROB_idx = 5'd1;
      retire_en = 1'b1; retire_dest_idx = 5'd4; rob_fl_out.Told_idx = 6'd11;
      rollback_en = 1'b1; ROB_rollback_idx = 5'd6;
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      #1;
      $display("mid-sequence reset -> free_count=%0d FL_valid=%0b T_idx=%0d", free_count, fl_valid, fl_rob_out.T_idx);
      checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL mid_reset_count: got %0d expected 32", free_count); end
      checks++; if (fl_valid !== 1'b1) begin errors++; $display("FAIL mid_reset_valid: got %0b expected 1", fl_valid); end
      checks++; if (fl_rob_out.T_idx !== 6'd32) begin errors++; $display("FAIL mid_reset_T_idx: got %0d expected 32", fl_rob_out.T_idx); end
      dispatch_en = 1'b1;
      step();
      idle();
      #1;
      checks++; if (fl_rob_out.T_idx !== 6'd33) begin errors++; $display("FAIL mid_reset_entry1: got %0d expected 33", fl_rob_out.T_idx); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_dispatch();
      test_zero_dest();
      test_full();
      test_rollback();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the R10000-style rename stage.
- Supplies a free physical register (T_idx) to the ROB and map table at dispatch.
- Reclaims Told_idx when the ROB retires an instruction.
- On branch rollback, restores its head pointer from a per-ROB-entry checkpoint so that registers allocated by squashed instructions become free again.

Parameters:
- NUM_PR, 64, physical registers; PR index width = $clog2(NUM_PR).
- NUM_AR, 32, architectural registers; FL_SIZE = NUM_PR - NUM_AR.
- NUM_ROB, 32, ROB entries; checkpoint table depth.
- ZERO_REG, 31, architectural zero register; never allocates and never frees.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; takes priority over everything
- en  in  1  global stall-free enable; no state changes when low
- dispatch_en  in  1  dispatch request this cycle (same qualifier the ROB receives)
- dispatch_dest_idx  in  5  architectural destination of the dispatching instruction
- dispatch_ROB_idx  in  $clog2(NUM_ROB)  ROB slot being written this cycle
- retire_en  in  1  ROB head retiring this cycle
- retire_dest_idx  in  5  architectural destination of the retiring instruction
- ROB_FL_out  in  ROB_FL_OUT_t  Told_idx of the retiring instruction
- rollback_en  in  1  branch mispredict rollback
- ROB_rollback_idx  in  $clog2(NUM_ROB)  ROB index of the mispredicted branch (kept)
- FL_valid  out  1  a free register is available for dispatch
- FL_ROB_out  out  FL_ROB_OUT_t  T_idx for the dispatching instruction
- free_count  out  $clog2(FL_SIZE)+1  number of free entries

Behaviour:
- Storage:
  - circular array fl[FL_SIZE] of PR indices.
  - head and tail pointers, each $clog2(FL_SIZE)+1 bits; the MSB is the wrap bit.
  - free_count = tail - head, computed modulo 2^(ptr width).
- Reset values:
  - fl[i] = NUM_AR + i; head = 0; tail = FL_SIZE, so free_count = FL_SIZE and the list is full.
  - all checkpoint entries = 0; FL_valid = 1; T_idx = NUM_AR.
- Outputs are combinational from registered state:
  - T_idx = fl[head[low bits]].
  - When dispatch_dest_idx == ZERO_REG, T_idx = ZERO_PR (= ZERO_REG) and no pop occurs.
  - FL_valid = (free_count != 0) || (dispatch_dest_idx == ZERO_REG).
- Pop (allocate):
  - occurs when en && dispatch_en && FL_valid && !rollback_en && dispatch_dest_idx != ZERO_REG.
  - head <= head + 1.
- Checkpoint:
  - on any accepted dispatch (en && dispatch_en && !rollback_en), write ckpt[dispatch_ROB_idx] <= post-dispatch head.
  - this applies whether or not the instruction popped.
- Push (reclaim):
  - occurs when en && retire_en && retire_dest_idx != ZERO_REG.
  - fl[tail] <= Told_idx; tail <= tail + 1.
- Rollback:
  - occurs when en && rollback_en; head <= ckpt[ROB_rollback_idx].
  - any dispatch in the same cycle is ignored, matching the ROB, which blocks writeTail on rollback.
- Simultaneous events:
  - retire and dispatch in one cycle: both act; the pop reads the old head, and no bypass from the pushed value is needed.
  - retire and rollback in one cycle: the push to the tail still occurs and head is restored. Register conservation guarantees the push never overwrites the restored range.
  - dispatch when free_count == 0 with a real destination: FL_valid = 0, the dispatch stage stalls, no pop occurs, and the checkpoint is not written.
- Wrap-around: pointer low bits index fl; the MSB distinguishes full from empty. free_count never exceeds FL_SIZE in legal operation.
- Assertion (simulation only): free_count <= FL_SIZE at all times; an overflowing push is an error.
- Latency: T_idx is visible in the same cycle as the dispatch request; updated state is visible the next cycle.
- Reset mid-operation restores the full initial list regardless of in-flight rollback or retire activity.

Decomposition:
- In sys_defs:
  - FL_ROB_OUT_t {T_idx} and ROB_FL_OUT_t {Told_idx} (existing).
  - new FL_t {fl array, head, tail}.
  - macros `NUM_PR, `NUM_FL (= FL_SIZE), `ZERO_REG.
- Single module; the checkpoint table is a plain register array with no sub-module.

Test Plan:
- Reset, then dispatch dest=1,2,3 on consecutive cycles -> T_idx 32,33,34; free_count 32→29; FL_valid=1.
- Dispatch with dest=ZERO_REG -> T_idx=31, head unchanged, free_count unchanged, checkpoint written.
- 32 dispatches with real destinations -> free_count=0, FL_valid=0; 33rd request produces no pop. Retire Told=5 -> next cycle free_count=1, T_idx=5; head wraps to 0.
- Dispatch ROB idx 4,5,6 (T=32,33,34), then rollback with ROB_rollback_idx=4 -> head restored to 1, next T_idx=33, free_count=31.
- Same-cycle retire (Told=7) and dispatch -> T_idx=old head value, tail+1 and head+1, free_count unchanged.
- Same-cycle rollback and dispatch -> dispatch ignored, head = checkpoint value; assert reset mid-sequence -> full initial contents restored.
